// File: rtl/lii_gather_scatter_wrapper_if.sv
// rtl/lii_gather_scatter_wrapper_if.sv - phy-side LII channel and kernel-side stream interfaces
interface lii_phy_if #(
  parameter int PW = 64
) ();
  logic [PW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic [7:0]    src;
  logic [7:0]    dst;

  modport master (output tdata, output tvalid, output src, output dst, input tready);
  modport slave  (input tdata, input tvalid, input src, input dst, output tready);
endinterface

interface lii_stream_if #(
  parameter int W = 16
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/lii_gather_scatter_wrapper.sv
// rtl/lii_gather_scatter_wrapper.sv - gathers phy beats into kernel words and scatters kernel words into phy beats
module lii_gather_scatter_wrapper #(
  parameter int          NIN      = 1,
  parameter int          NOUT     = 1,
  parameter int          DW       = 16,
  parameter int          PW       = 64,
  parameter logic [7:0]  LOCAL_ID = 8'd0,
  parameter logic [7:0]  DST_ID   = 8'd0
) (
  input  logic          aclk,
  input  logic          arst,
  lii_phy_if.slave      lii_in_p0,
  lii_phy_if.master     lii_out_p0,
  lii_stream_if.master  in_stream,
  lii_stream_if.slave   out_stream,
  output logic          ce,
  output logic [15:0]   drop_cnt
);
  localparam int IBEATS = (NIN * DW + PW - 1) / PW;
  localparam int OBEATS = (NOUT * DW + PW - 1) / PW;
  localparam int IBW    = (IBEATS > 1) ? $clog2(IBEATS) : 1;
  localparam int OBW    = (OBEATS > 1) ? $clog2(OBEATS) : 1;
  localparam logic [IBW-1:0] ILAST = IBW'(IBEATS - 1);
  localparam logic [OBW-1:0] OLAST = OBW'(OBEATS - 1);

  typedef enum logic {GATHER, HOLD} gstate_t;
  typedef enum logic {IDLE, SEND}   sstate_t;

  gstate_t              gstate, gstate_nxt;
  logic [IBW-1:0]       ibeat, ibeat_nxt;
  logic [NIN*DW-1:0]    asm_q;
  logic                 in_acc, in_hit, kin_hs;

  sstate_t              sstate, sstate_nxt;
  logic [OBW-1:0]       obeat, obeat_nxt;
  logic [OBEATS*PW-1:0] cap_q;
  logic                 phy_hs, kout_hs;

  // Gather side: HOLD presents the assembled word; HOLD with a ready kernel still accepts beats
  assign lii_in_p0.tready = ~arst & ((gstate == GATHER) | ((gstate == HOLD) & in_stream.tready));
  assign in_acc           = lii_in_p0.tvalid & lii_in_p0.tready;
  assign in_hit           = in_acc & (lii_in_p0.dst == LOCAL_ID);
  assign in_stream.tvalid = (gstate == HOLD);
  assign in_stream.tdata  = asm_q;
  assign kin_hs           = in_stream.tvalid & in_stream.tready;

  always_ff @(posedge aclk) begin
    if (arst) begin
      gstate <= GATHER;
      ibeat  <= '0;
    end else begin
      gstate <= gstate_nxt;
      ibeat  <= ibeat_nxt;
    end
  end

  always_comb begin
    gstate_nxt = gstate;
    ibeat_nxt  = ibeat;
    if (kin_hs) gstate_nxt = GATHER;
    if (in_hit) begin
      if (ibeat == ILAST) begin
        ibeat_nxt  = '0;
        gstate_nxt = HOLD;
      end else begin
        ibeat_nxt = ibeat + 1'b1;
      end
    end
  end

  // Only bits that land inside the kernel word are stored; the tail of the last beat is dropped
  always_ff @(posedge aclk) begin
    if (in_hit) begin
      for (int i = 0; i < NIN * DW; i++) begin
        if (IBW'(i / PW) == ibeat) asm_q[i] <= lii_in_p0.tdata[i % PW];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) drop_cnt <= '0;
    else if (in_acc && (lii_in_p0.dst != LOCAL_ID) && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
  end

  // Scatter side: a new kernel word is taken only when idle or while the last beat leaves
  assign out_stream.tready = ~arst & ((sstate == IDLE) | ((sstate == SEND) & (obeat == OLAST) & lii_out_p0.tready));
  assign kout_hs           = out_stream.tvalid & out_stream.tready;
  assign lii_out_p0.tvalid = (sstate == SEND);
  assign lii_out_p0.tdata  = cap_q[obeat*PW +: PW];
  assign lii_out_p0.src    = LOCAL_ID;
  assign lii_out_p0.dst    = DST_ID;
  assign phy_hs            = lii_out_p0.tvalid & lii_out_p0.tready;

  always_ff @(posedge aclk) begin
    if (arst) begin
      sstate <= IDLE;
      obeat  <= '0;
    end else begin
      sstate <= sstate_nxt;
      obeat  <= obeat_nxt;
    end
  end

  always_comb begin
    sstate_nxt = sstate;
    obeat_nxt  = obeat;
    if (phy_hs) begin
      if (obeat == OLAST) begin
        sstate_nxt = IDLE;
        obeat_nxt  = '0;
      end else begin
        obeat_nxt = obeat + 1'b1;
      end
    end
    if (kout_hs) begin
      sstate_nxt = SEND;
      obeat_nxt  = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (kout_hs) cap_q <= (OBEATS*PW)'(out_stream.tdata);
  end

  assign ce = ~(in_stream.tvalid & ~in_stream.tready) & ~(out_stream.tvalid & ~out_stream.tready);
endmodule

// File: tb/tb_lii_gather_scatter_wrapper.sv
// tb/tb_lii_gather_scatter_wrapper.sv - self-checking bench for lii_gather_scatter_wrapper
module tb_lii_gather_scatter_wrapper;
  localparam int PW = 64;
  localparam int DW = 16;
  localparam int A_NIN = 8, A_NOUT = 6, B_NIN = 4, B_NOUT = 3;
  localparam logic [7:0] A_LID = 8'h05, A_DST = 8'h3C, B_LID = 8'h07, B_DST = 8'h11;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        a_ce, b_ce;
  logic [15:0] a_drop, b_drop;

  always #5 aclk = ~aclk;

  lii_phy_if #(.PW(PW)) a_pin (), a_pout (), b_pin (), b_pout ();
  lii_stream_if #(.W(A_NIN*DW))  a_kin ();
  lii_stream_if #(.W(A_NOUT*DW)) a_kout ();
  lii_stream_if #(.W(B_NIN*DW))  b_kin ();
  lii_stream_if #(.W(B_NOUT*DW)) b_kout ();

  lii_gather_scatter_wrapper #(.NIN(A_NIN), .NOUT(A_NOUT), .DW(DW), .PW(PW), .LOCAL_ID(A_LID), .DST_ID(A_DST)) dut_a (
    .aclk(aclk), .arst(arst), .lii_in_p0(a_pin), .lii_out_p0(a_pout),
    .in_stream(a_kin), .out_stream(a_kout), .ce(a_ce), .drop_cnt(a_drop));

  lii_gather_scatter_wrapper #(.NIN(B_NIN), .NOUT(B_NOUT), .DW(DW), .PW(PW), .LOCAL_ID(B_LID), .DST_ID(B_DST)) dut_b (
    .aclk(aclk), .arst(arst), .lii_in_p0(b_pin), .lii_out_p0(b_pout),
    .in_stream(b_kin), .out_stream(b_kout), .ce(b_ce), .drop_cnt(b_drop));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  logic [63:0]  beats[$];
  logic [127:0] exp_k[$];
  logic [63:0]  exp_p[$];
  logic [63:0]  w_in[100];
  logic [47:0]  w_out[100];
  logic [127:0] zext;
  int           drops;
  logic         kv, pv, pin_rdy, kout_rdy;

  initial begin
    a_pin.tvalid = 0; a_pin.tdata = '0; a_pin.src = 8'h00; a_pin.dst = 8'h00;
    b_pin.tvalid = 0; b_pin.tdata = '0; b_pin.src = 8'h00; b_pin.dst = 8'h00;
    a_pout.tready = 0; b_pout.tready = 0;
    a_kin.tready = 0; b_kin.tready = 0;
    a_kout.tvalid = 0; a_kout.tdata = '0;
    b_kout.tvalid = 0; b_kout.tdata = '0;

    // reset state
    repeat (2) cyc();
    @(negedge aclk);
    chk("rst_in_tready", a_pin.tready, 1'b0);
    chk("rst_out_stream_tready", a_kout.tready, 1'b0);
    chk("rst_in_stream_tvalid", a_kin.tvalid, 1'b0);
    chk("rst_phy_tvalid", a_pout.tvalid, 1'b0);
    chk("rst_drop_cnt", a_drop, 16'd0);
    cyc();
    arst = 0;

    // gather two beats with a misaddressed word between them
    a_pin.tvalid = 1; a_pin.tdata = {4{16'h1111}}; a_pin.dst = A_LID;
    @(negedge aclk);
    chk("g_tready_gather", a_pin.tready, 1'b1);
    cyc();
    a_pin.tdata = 64'hDEAD_BEEF_DEAD_BEEF; a_pin.dst = A_LID ^ 8'h01;
    @(negedge aclk);
    chk("g_no_valid_mid", a_kin.tvalid, 1'b0);
    cyc();
    a_pin.tdata = {4{16'h2222}}; a_pin.dst = A_LID;
    @(negedge aclk);
    chk("g_drop_one", a_drop, 16'd1);
    chk("g_no_valid_after_drop", a_kin.tvalid, 1'b0);
    cyc();
    a_pin.tvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("g_valid", a_kin.tvalid, 1'b1);
      chk("g_data", a_kin.tdata, {{4{16'h2222}}, {4{16'h1111}}});
      chk("g_hold_in_tready", a_pin.tready, 1'b0);
      chk("g_hold_ce", a_ce, 1'b0);
      cyc();
    end
    a_kin.tready = 1;
    @(negedge aclk);
    chk("g_hs_in_tready", a_pin.tready, 1'b1);
    chk("g_hs_ce", a_ce, 1'b1);
    cyc();
    a_kin.tready = 0;
    @(negedge aclk);
    chk("g_back_to_gather", a_kin.tvalid, 1'b0);
    cyc();

    // scatter one word with 5 cycles of phy backpressure
    a_kout.tvalid = 1; a_kout.tdata = 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    @(negedge aclk);
    chk("s_idle_tready", a_kout.tready, 1'b1);
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("s_stall_valid", a_pout.tvalid, 1'b1);
      chk("s_stall_data", a_pout.tdata, 64'hCCCC_DDDD_EEEE_FFFF);
      chk("s_stall_out_tready", a_kout.tready, 1'b0);
      chk("s_stall_ce", a_ce, 1'b0);
      cyc();
    end
    a_pout.tready = 1; a_kout.tvalid = 0;
    @(negedge aclk);
    chk("s_beat0", a_pout.tdata, 64'hCCCC_DDDD_EEEE_FFFF);
    chk("s_src", a_pout.src, A_LID);
    chk("s_dst", a_pout.dst, A_DST);
    cyc();
    @(negedge aclk);
    chk("s_beat1_valid", a_pout.tvalid, 1'b1);
    chk("s_beat1", a_pout.tdata, 64'h0000_0000_AAAA_BBBB);
    chk("s_last_out_tready", a_kout.tready, 1'b1);
    cyc();
    a_pout.tready = 0;
    @(negedge aclk);
    chk("s_idle_again", a_pout.tvalid, 1'b0);

    // reset in the middle of a gather and a send
    cyc();
    a_pin.tvalid = 1; a_pin.tdata = {4{16'h3333}}; a_pin.dst = A_LID;
    a_kout.tvalid = 1; a_kout.tdata = 96'h1234_5678_9ABC_DEF0_1357_9BDF;
    cyc();
    a_pin.tvalid = 0; a_kout.tvalid = 0;
    arst = 1;
    cyc();
    arst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("r_no_kernel_word", a_kin.tvalid, 1'b0);
      chk("r_no_phy_beat", a_pout.tvalid, 1'b0);
      cyc();
    end
    a_pin.tvalid = 1; a_pin.tdata = {4{16'h4444}};
    cyc();
    a_pin.tdata = {4{16'h5555}};
    cyc();
    a_pin.tvalid = 0;
    @(negedge aclk);
    chk("r_clean_valid", a_kin.tvalid, 1'b1);
    chk("r_clean_data", a_kin.tdata, {{4{16'h5555}}, {4{16'h4444}}});
    a_kin.tready = 1;
    cyc();
    a_kin.tready = 0;

    // full-rate streaming through the single-beat instance
    for (int i = 0; i < 100; i++) begin
      w_in[i]  = {$urandom, $urandom};
      w_out[i] = {$urandom, $urandom};
    end
    b_kin.tready = 1; b_pout.tready = 1;
    for (int j = 0; j <= 100; j++) begin
      if (j < 100) begin
        b_pin.tvalid = 1; b_pin.tdata = w_in[j]; b_pin.dst = B_LID;
        b_kout.tvalid = 1; b_kout.tdata = w_out[j];
      end else begin
        b_pin.tvalid = 0; b_kout.tvalid = 0;
      end
      @(negedge aclk);
      if (j < 100) begin
        chk("t_in_tready", b_pin.tready, 1'b1);
        chk("t_out_stream_tready", b_kout.tready, 1'b1);
      end
      if (j >= 1) begin
        chk("t_kin_valid", b_kin.tvalid, 1'b1);
        chk("t_kin_data", b_kin.tdata, w_in[j-1]);
        chk("t_phy_valid", b_pout.tvalid, 1'b1);
        chk("t_phy_data", b_pout.tdata, {16'h0000, w_out[j-1]});
        chk("t_phy_dst", b_pout.dst, B_DST);
      end
      cyc();
    end
    @(negedge aclk);
    chk("t_drained_kin", b_kin.tvalid, 1'b0);
    chk("t_drained_phy", b_pout.tvalid, 1'b0);
    chk("t_no_drops", b_drop, 16'd0);
    cyc();

    // randomized traffic against a queue model
    arst = 1;
    cyc();
    arst = 0;
    drops = 0;
    for (int c = 0; c < 600; c++) begin
      a_pin.tvalid  = 1'($urandom_range(0, 1));
      a_pin.tdata   = {$urandom, $urandom};
      a_pin.dst     = ($urandom_range(0, 3) == 0) ? (A_LID + 8'd1) : A_LID;
      a_kin.tready  = 1'($urandom_range(0, 1));
      a_kout.tvalid = 1'($urandom_range(0, 1));
      a_kout.tdata  = {$urandom, $urandom, $urandom};
      a_pout.tready = 1'($urandom_range(0, 1));
      @(negedge aclk);
      kv = (exp_k.size() != 0);
      pv = (exp_p.size() != 0);
      chk("m_kin_valid", a_kin.tvalid, kv);
      if (kv) chk("m_kin_data", a_kin.tdata, exp_k[0]);
      chk("m_phy_valid", a_pout.tvalid, pv);
      if (pv) begin
        chk("m_phy_data", a_pout.tdata, exp_p[0]);
        chk("m_phy_src", a_pout.src, A_LID);
      end
      pin_rdy  = !kv || a_kin.tready;
      kout_rdy = (exp_p.size() == 0) || (exp_p.size() == 1 && a_pout.tready);
      chk("m_in_tready", a_pin.tready, pin_rdy);
      chk("m_out_stream_tready", a_kout.tready, kout_rdy);
      chk("m_ce", a_ce, !(kv && !a_kin.tready) && !(a_kout.tvalid && !kout_rdy));
      if (kv && a_kin.tready) void'(exp_k.pop_front());
      if (a_pin.tvalid && pin_rdy) begin
        if (a_pin.dst == A_LID) begin
          beats.push_back(a_pin.tdata);
          if (beats.size() == 2) begin
            exp_k.push_back({beats[1], beats[0]});
            beats.delete();
          end
        end else if (drops < 65535) begin
          drops++;
        end
      end
      if (pv && a_pout.tready) void'(exp_p.pop_front());
      if (a_kout.tvalid && kout_rdy) begin
        zext = {32'h0, a_kout.tdata};
        exp_p.push_back(zext[63:0]);
        exp_p.push_back(zext[127:64]);
      end
      cyc();
    end
    a_pin.tvalid = 0; a_kout.tvalid = 0; a_kin.tready = 0; a_pout.tready = 0;
    @(negedge aclk);
    chk("m_drop_total", a_drop, 16'(drops));

    // drop counter saturation
    cyc();
    arst = 1;
    cyc();
    arst = 0;
    a_pin.tvalid = 1; a_pin.dst = A_LID ^ 8'h80; a_pin.tdata = 64'h0;
    for (int i = 0; i <= 65536; i++) begin
      if (i == 100 || i == 65534 || i == 65535 || i == 65536) begin
        @(negedge aclk);
        chk("sat_drop_cnt", a_drop, (i > 65535) ? 16'hFFFF : 16'(i));
      end
      cyc();
    end
    a_pin.tvalid = 0;
    @(negedge aclk);
    chk("sat_final", a_drop, 16'hFFFF);
    chk("sat_no_word", a_kin.tvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lii_gather_scatter_wrapper.md
LII_GATHER_SCATTER_WRAPPER -- requirements
Module: lii_gather_scatter_wrapper

Interface
REQ-001 SHALL have parameter NIN, default 1, meaning number of logical kernel input lanes.
REQ-002 SHALL have parameter NOUT, default 1, meaning number of logical kernel output lanes.
REQ-003 SHALL have parameter DW, default 16, meaning bits per logical lane.
REQ-004 SHALL have parameter PW, default 64, meaning phy packing width.
REQ-005 SHALL have parameter LOCAL_ID, default 0, meaning 8-bit node ID of this wrapper.
REQ-006 SHALL have parameter DST_ID, default 0, meaning 8-bit destination ID for outgoing words.
REQ-007 SHALL define derived constants IBEATS = ceil(NIN*DW/PW) and OBEATS = ceil(NOUT*DW/PW).
REQ-008 SHALL have port aclk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-009 SHALL have port arst, input, 1; reset is synchronous and active-high.
REQ-010 SHALL have ports lii_in_p0_tdata/tvalid/src/dst (inputs: PW, 1, 8, 8) and lii_in_p0_tready (output, 1), meaning the phy input channel.
REQ-011 SHALL have ports lii_out_p0_tdata/tvalid/src/dst (outputs: PW, 1, 8, 8) and lii_out_p0_tready (input, 1), meaning the phy output channel.
REQ-012 SHALL have ports in_stream_tdata (output, NIN*DW), in_stream_tvalid (output, 1) and in_stream_tready (input, 1), meaning the kernel input stream.
REQ-013 SHALL have ports out_stream_tdata (input, NOUT*DW), out_stream_tvalid (input, 1) and out_stream_tready (output, 1), meaning the kernel output stream.
REQ-014 SHALL have ports ce (output, 1, kernel clock enable) and drop_cnt (output, 16, count of misaddressed words).

Function
REQ-015 Gather FSM SHALL have two states, GATHER and HOLD, plus a beat counter ibeat in the range 0..IBEATS-1.
REQ-016 lii_in_p0_tready SHALL equal (state==GATHER) | (state==HOLD & in_stream_tready).
REQ-017 An accepted input word with lii_in_p0_dst==LOCAL_ID SHALL be written to assembly bits [ibeat*PW +: PW], with bits above NIN*DW discarded.
REQ-018 An accepted word with dst!=LOCAL_ID SHALL be discarded without advancing ibeat, and drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-019 On acceptance of the beat at ibeat==IBEATS-1: ibeat SHALL go to 0, state SHALL go to HOLD, and in_stream_tvalid SHALL be 1 on the next cycle (latency 1 cycle after the last beat).
REQ-020 In HOLD, in_stream_tdata and in_stream_tvalid SHALL stay stable until in_stream_tready=1; the handshake SHALL return the FSM to GATHER unless a new final beat is accepted in the same cycle.
REQ-021 A beat accepted in the same cycle as a HOLD handshake SHALL start the next gather with no bubble, giving one kernel word per cycle when IBEATS=1.
REQ-022 Scatter FSM SHALL have two states, IDLE and SEND, plus a beat counter obeat in the range 0..OBEATS-1.
REQ-023 out_stream_tready SHALL equal (state==IDLE) | (state==SEND & obeat==OBEATS-1 & lii_out_p0_tready).
REQ-024 On an out_stream handshake, the wrapper SHALL capture out_stream_tdata zero-extended to OBEATS*PW, set obeat=0 and enter SEND.
REQ-025 In SEND, lii_out_p0_tvalid SHALL be 1 and lii_out_p0_tdata SHALL equal captured bits [obeat*PW +: PW]; each lii_out_p0_tready SHALL advance obeat.
REQ-026 After the last beat is accepted, the scatter FSM SHALL return to IDLE, unless REQ-023 captures a new word in the same cycle.
REQ-027 lii_out_p0_src SHALL be LOCAL_ID and lii_out_p0_dst SHALL be DST_ID at all times.
REQ-028 ce SHALL equal ~(in_stream_tvalid & ~in_stream_tready) & ~(out_stream_tvalid & ~out_stream_tready); it is combinational.
REQ-029 Input and output paths SHALL operate independently and concurrently.

Reset
REQ-030 While arst=1 at a clock edge, the next state SHALL be: both FSMs in GATHER/IDLE, ibeat=obeat=0, in_stream_tvalid=0, lii_out_p0_tvalid=0, drop_cnt=0.
REQ-031 Reset asserted mid-gather or mid-send SHALL discard partial words, with no phy or kernel beat emitted afterwards.
REQ-032 During reset, lii_in_p0_tready and out_stream_tready SHALL be 0.

Verification
REQ-033 Gather, NIN=8, DW=16, PW=64: beats 0x1111..., 0x2222... with dst=LOCAL_ID -> in_stream_tdata={0x2222...,0x1111...}, tvalid=1 one cycle after beat 2.
REQ-034 Drop: a dst!=LOCAL_ID word between the two beats -> word ignored, drop_cnt=1, assembled word unchanged; after 65536 drops drop_cnt=0xFFFF.
REQ-035 Scatter, NOUT=6, DW=16, PW=64 (OBEATS=2): out_stream_tdata=0xAAAA_BBBB_CCCC_DDDD_EEEE_FFFF -> phy beats 0xCCCC_DDDD_EEEE_FFFF, then 0x0000_0000_AAAA_BBBB, with src=LOCAL_ID and dst=DST_ID.
REQ-036 Backpressure: lii_out_p0_tready=0 for 5 cycles mid-send -> tdata held stable, out_stream_tready=0, ce=0 while out_stream_tvalid=1.
REQ-037 Throughput, IBEATS=1 and OBEATS=1, all readies high -> one word per cycle with no bubbles over 100 words.
REQ-038 Reset mid-operation: arst pulse after 1 of 2 beats -> no in_stream_tvalid; the next two beats form a clean word.
